// File: rtl/req_encoder_8x3.sv
`default_nettype none
// ============================================================================
//  Module      : req_encoder_8x3
//  Description : Sequential 8-to-3 encoder. Captures an 8-bit request vector
//                and emits the index of each set bit, lowest first, one code
//                per valid/ready transfer. Pulses done at the end of a batch,
//                empty on an all-zero load and load_err on a load while busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module req_encoder_8x3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req_in,
    input  logic       req_load,
    output logic [2:0] code_out,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       busy,
    output logic       done,
    output logic       empty,
    output logic       load_err,
    output logic [3:0] count
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_pending;
    logic [2:0] r_code;
    logic       r_valid;
    logic       r_busy;
    logic       r_done;
    logic       r_empty;
    logic       r_load_err;
    logic [3:0] r_count;

    logic [7:0] w_pending_nxt;
    logic [2:0] w_code_nxt;
    logic       w_valid_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic       w_empty_nxt;
    logic       w_load_err_nxt;
    logic [3:0] w_count_nxt;

    logic       w_xfer;
    logic [7:0] w_code_onehot;
    logic [7:0] w_pending_left;

    // Index of the lowest set bit; scanning downwards lets the lowest win.
    function automatic logic [2:0] f_lowest(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // The pending bit being served is cleared on each accepted transfer.
    assign w_xfer         = r_valid & code_ready;
    assign w_code_onehot  = 8'b0000_0001 << r_code;
    assign w_pending_left = r_pending & ~w_code_onehot;

    // State register; the FSM sits in EMIT for exactly the life of a batch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode; abort takes priority over the
    // end-of-batch path, but a transfer in the abort cycle is still counted.
    always_comb begin
        w_state_nxt    = r_state;
        w_pending_nxt  = r_pending;
        w_code_nxt     = r_code;
        w_valid_nxt    = r_valid;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_empty_nxt    = 1'b0;
        w_load_err_nxt = 1'b0;
        w_count_nxt    = r_count;

        case (r_state)
            S_IDLE: begin
                if (en && req_load) begin
                    w_count_nxt = 4'd0;
                    if (req_in != 8'd0) begin
                        w_pending_nxt = req_in;
                        w_code_nxt    = f_lowest(req_in);
                        w_valid_nxt   = 1'b1;
                        w_busy_nxt    = 1'b1;
                        w_state_nxt   = S_EMIT;
                    end else begin
                        w_empty_nxt   = 1'b1;
                    end
                end
            end

            S_EMIT: begin
                w_load_err_nxt = req_load;

                if (w_xfer) begin
                    w_pending_nxt = w_pending_left;
                    w_count_nxt   = r_count + 4'd1;
                end

                if (!en) begin
                    w_pending_nxt = 8'd0;
                    w_valid_nxt   = 1'b0;
                    w_busy_nxt    = 1'b0;
                    w_state_nxt   = S_IDLE;
                end else if (w_xfer) begin
                    if (w_pending_left != 8'd0) begin
                        w_code_nxt  = f_lowest(w_pending_left);
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and output registers; every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending  <= 8'd0;
            r_code     <= 3'd0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_empty    <= 1'b0;
            r_load_err <= 1'b0;
            r_count    <= 4'd0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_code     <= w_code_nxt;
            r_valid    <= w_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_empty    <= w_empty_nxt;
            r_load_err <= w_load_err_nxt;
            r_count    <= w_count_nxt;
        end
    end

    assign code_out   = r_code;
    assign code_valid = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign empty      = r_empty;
    assign load_err   = r_load_err;
    assign count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_req_encoder_8x3.sv
`default_nettype none
// ============================================================================
//  Module      : tb_req_encoder_8x3
//  Description : Self-checking bench for req_encoder_8x3. A queue-based model
//                of pending request indices is compared with the DUT every
//                cycle; directed scenarios add hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_req_encoder_8x3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] req_in = 8'd0;
    logic       req_load = 1'b0;
    logic       code_ready = 1'b0;
    logic [2:0] code_out;
    logic       code_valid;
    logic       busy;
    logic       done;
    logic       empty;
    logic       load_err;
    logic [3:0] count;

    int n_checks = 0;
    int n_errors = 0;

    req_encoder_8x3 u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req_in     (req_in),
        .req_load   (req_load),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .busy       (busy),
        .done       (done),
        .empty      (empty),
        .load_err   (load_err),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // 3-to-8 one-hot decoder used for the loopback scenario.
    function automatic logic [7:0] f_dec(input logic [2:0] c, input logic e);
        logic [7:0] one;
        one = 8'd1;
        return e ? (one << c) : 8'd0;
    endfunction

    // ---------------- behavioural model: queue of indices still to serve ---
    int m_q[$];
    bit m_busy  = 1'b0;
    bit m_done  = 1'b0;
    bit m_empty = 1'b0;
    bit m_err   = 1'b0;
    int m_count = 0;
    bit m_init  = 1'b0;

    always @(posedge clk) begin
        m_done  = 1'b0;
        m_empty = 1'b0;
        m_err   = 1'b0;
        if (!rst_n) begin
            m_q.delete();
            m_busy  = 1'b0;
            m_count = 0;
            m_init  = 1'b1;
        end else if (!m_busy) begin
            if (en && req_load) begin
                m_count = 0;
                if (req_in == 8'd0) begin
                    m_empty = 1'b1;
                end else begin
                    m_q.delete();
                    for (int i = 0; i < 8; i++) begin
                        if (req_in[i]) m_q.push_back(i);
                    end
                    m_busy = 1'b1;
                end
            end
        end else begin
            if (req_load) m_err = 1'b1;
            if (code_ready) begin
                void'(m_q.pop_front());
                m_count++;
            end
            if (!en) begin
                m_q.delete();
                m_busy = 1'b0;
            end else if (m_q.size() == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (m_init) begin
            chk("valid",    int'(code_valid), int'(m_busy));
            chk("busy",     int'(busy),       int'(m_busy));
            chk("done",     int'(done),       int'(m_done));
            chk("empty",    int'(empty),      int'(m_empty));
            chk("load_err", int'(load_err),   int'(m_err));
            chk("count",    int'(count),      m_count);
            if (m_busy && m_q.size() > 0) begin
                chk("code", int'(code_out), m_q[0]);
            end
        end
    end

    // ---------------- stimulus with hand-computed expectations -------------
    initial begin
        logic [7:0] acc;
        bit         seen_done;

        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_valid", int'(code_valid), 0);
        chk("rst_count", int'(count), 0);
        rst_n = 1'b1;
        en    = 1'b1;

        // Reset in the middle of a batch.
        req_in = 8'hFF; req_load = 1'b1; code_ready = 1'b0;
        tick();
        req_load = 1'b0; code_ready = 1'b1;
        tick(); tick(); tick();
        chk("mid_count3", int'(count), 3);
        chk("mid_code3", int'(code_out), 3);
        code_ready = 1'b0; rst_n = 1'b0;
        tick();
        chk("mid_rst_all", int'({code_out, code_valid, busy, done, empty, load_err, count}), 0);
        rst_n = 1'b1; req_in = 8'h01; req_load = 1'b1;
        tick();
        req_load = 1'b0;
        chk("post_rst_code", int'(code_out), 0);
        chk("post_rst_valid", int'(code_valid), 1);
        code_ready = 1'b1;
        tick();
        chk("post_rst_done", int'(done), 1);
        code_ready = 1'b0;

        // Full batch with ready held high.
        req_in = 8'b1010_0110; req_load = 1'b1; code_ready = 1'b1;
        tick();
        req_load = 1'b0;
        chk("model_qsize", m_q.size(), 4);
        chk("full_c0", int'(code_out), 1);
        tick();
        chk("full_c1", int'(code_out), 2);
        tick();
        chk("full_c2", int'(code_out), 5);
        tick();
        chk("full_c3", int'(code_out), 7);
        tick();
        chk("full_done", int'(done), 1);
        chk("full_count", int'(count), 4);
        chk("full_valid", int'(code_valid), 0);
        tick();
        chk("full_done_gone", int'(done), 0);
        code_ready = 1'b0;

        // Backpressure.
        req_in = 8'h81; req_load = 1'b1;
        tick();
        req_load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_code", int'(code_out), 0);
            chk("bp_valid", int'(code_valid), 1);
            tick();
        end
        code_ready = 1'b1;
        tick();
        chk("bp_code7", int'(code_out), 7);
        tick();
        chk("bp_done", int'(done), 1);
        code_ready = 1'b0;

        // Empty load, then a load attempted while busy.
        req_in = 8'h00; req_load = 1'b1;
        tick();
        req_load = 1'b0;
        chk("empty_pulse", int'(empty), 1);
        chk("empty_busy", int'(busy), 0);
        tick();
        chk("empty_gone", int'(empty), 0);
        req_in = 8'h10; req_load = 1'b1;
        tick();
        chk("bl_code4", int'(code_out), 4);
        req_in = 8'hFF;
        tick();
        req_load = 1'b0;
        chk("bl_err", int'(load_err), 1);
        chk("bl_code_hold", int'(code_out), 4);
        code_ready = 1'b1;
        tick();
        chk("bl_done", int'(done), 1);
        chk("bl_count", int'(count), 1);
        code_ready = 1'b0;

        // Abort coinciding with a transfer.
        req_in = 8'h0F; req_load = 1'b1; code_ready = 1'b1;
        tick();
        req_load = 1'b0;
        tick();
        chk("ab_code1", int'(code_out), 1);
        en = 1'b0;
        tick();
        chk("ab_count", int'(count), 2);
        chk("ab_valid", int'(code_valid), 0);
        chk("ab_busy", int'(busy), 0);
        chk("ab_done", int'(done), 0);
        en = 1'b1; code_ready = 1'b0;
        tick();
        chk("ab_done_late", int'(done), 0);

        // Loopback through the 3-to-8 decoder.
        req_in = 8'h5A; req_load = 1'b1; code_ready = 1'b1;
        tick();
        req_load = 1'b0;
        acc = 8'd0;
        seen_done = 1'b0;
        for (int k = 0; k < 20 && !seen_done; k++) begin
            if (done) seen_done = 1'b1;
            else acc = acc | f_dec(code_out, code_valid);
            tick();
        end
        chk("loop_done_seen", int'(seen_done), 1);
        chk("loop_or", int'(acc), 8'h5A);
        code_ready = 1'b0;

        // Randomised traffic, checked by the every-cycle compare process.
        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 149) != 0);
            en         = ($urandom_range(0, 24) != 0);
            req_load   = ($urandom_range(0, 5) == 0);
            req_in     = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            code_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/req_encoder_8x3.md
# req_encoder_8x3

Sequential 8-to-3 encoder: the encoding counterpart of the team's 3-to-8 one-hot decoder. It captures an 8-bit request vector, then emits the index of every set bit as a 3-bit code, lowest index first, one code per valid/ready transfer. It sits between a bank of request sources and any consumer that drives the 3-to-8 decoder, so decoder(code_out) reproduces each served request bit.

## Interface
- No parameters; widths are fixed at 8 requests and 3-bit codes.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- en  input  1  block enable; low aborts any scan in progress.
- req_in  input  8  request vector; bit i requests code i.
- req_load  input  1  capture req_in (qualified by en).
- code_out  output  3  index of the current pending request (registered).
- code_valid  output  1  code_out holds a valid code (registered).
- code_ready  input  1  consumer accepts code_out.
- busy  output  1  scan in progress (state EMIT).
- done  output  1  one-cycle pulse after the last code of a batch is accepted.
- empty  output  1  one-cycle pulse when a load captures an all-zero vector.
- load_err  output  1  one-cycle pulse when req_load is asserted while busy.
- count  output  4  codes accepted since the last successful load (0..8).

## Operation
- Internal state: pending[7:0], plus two FSM states, IDLE and EMIT.
- Reset (rst_n=0 at an edge): state IDLE, pending=0.
  - Outputs: code_out=0, code_valid=0, busy=0, done=0, empty=0, load_err=0, count=0.
  - Reset overrides every other input, including mid-batch.
- IDLE, edge with en=1, req_load=1, req_in≠0:
  - pending←req_in, count←0.
  - code_out←index of lowest set bit of req_in, code_valid←1, busy←1.
  - Go to EMIT.
- IDLE, edge with en=1, req_load=1, req_in=0:
  - empty←1 for one cycle, count←0.
  - Stay in IDLE.
- IDLE with en=0: req_load is ignored and no pulse is generated.
- EMIT, transfer (code_valid=1 and code_ready=1 at an edge):
  - Clear pending[code_out] and increment count.
  - If pending bits remain, code_out←next lowest set index and code_valid stays 1. Back-to-back transfers are allowed.
  - If that was the last bit: code_valid←0, busy←0, done←1 for one cycle, go to IDLE.
- EMIT without code_ready: code_out and code_valid hold stable. Once valid is raised, it never drops without a transfer, except on abort or reset.
- EMIT, req_load=1: ignored. load_err←1 for one cycle; pending is unchanged.
- EMIT, en=0 at an edge (abort):
  - A transfer in that same cycle still completes and is counted.
  - Then pending←0, code_valid←0, busy←0, go to IDLE. done is not pulsed.
- Priority in EMIT: reset > abort > transfer. load_err can pulse in the same cycle as a transfer or an abort.
- count saturates naturally at 8 (maximum of 8 set bits) and has no wrap-around. Width rule: 4 bits.
- Bits of req_in that change after capture have no effect until the next load.

## Timing
- Load-to-first-code latency: load at edge N; code_valid=1 with the correct code_out during the cycle after N.
- Throughput: one code per cycle when code_ready is held high.
  - A batch of k set bits takes k cycles in EMIT.
  - done is high during cycle N+k+1.
- done, empty and load_err are each high for exactly one cycle.
- IDLE is entered in the same cycle that done is high, so a new load is accepted in the done cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset mid-batch: load 8'hFF, accept 3 codes, then assert rst_n=0 for one edge. Required: all outputs 0, state IDLE, and a following load of 8'h01 yields code 0.
- Full batch, ready high: load 8'b1010_0110 with code_ready=1. Required: codes 1, 2, 5, 7 on four consecutive cycles, then done for one cycle, and count=4.
- Backpressure: load 8'h81 and hold code_ready=0 for 5 cycles. Required: code_out=0 and code_valid=1 stay stable. Then raise ready: codes 0, then 7, then done.
- Empty load and busy load: load 8'h00 → empty pulses, busy=0. Load 8'h10, then req_load with 8'hFF while busy → load_err pulses and only code 4 is emitted.
- Abort with simultaneous transfer: load 8'h0F and accept code 0. Drop en in the same cycle code 1 transfers. Required: count=2, code_valid=0 next cycle, no done pulse, state IDLE.
- Loopback: drive code_out into the 3-to-8 decoder with en=1 and OR the decoded outputs over a batch of 8'h5A. Required: the OR equals 8'h5A.
